// File: rtl/fir_tap_sequencer_if.sv
// rtl/fir_tap_sequencer_if.sv - sample strobe, RAM address and MAC strobe bundle for the FIR tap sequencer
interface fir_tap_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              sample_en;
  logic [ADDR_W-1:0] taps_per_filter;
  logic              coef_wr_busy;
  logic              overrun_clr;
  logic              sample_we;
  logic [ADDR_W-1:0] sample_wr_addr;
  logic [ADDR_W-1:0] sample_rd_addr;
  logic [ADDR_W-1:0] coef_rd_addr;
  logic              mac_clr;
  logic              mac_en;
  logic              mac_last;
  logic              result_valid;
  logic              busy;
  logic              overrun;

  modport master (
    output sample_en, taps_per_filter, coef_wr_busy, overrun_clr,
    input  sample_we, sample_wr_addr, sample_rd_addr, coef_rd_addr,
           mac_clr, mac_en, mac_last, result_valid, busy, overrun
  );

  modport slave (
    input  sample_en, taps_per_filter, coef_wr_busy, overrun_clr,
    output sample_we, sample_wr_addr, sample_rd_addr, coef_rd_addr,
           mac_clr, mac_en, mac_last, result_valid, busy, overrun
  );
endinterface

// File: rtl/fir_tap_sequencer.sv
// rtl/fir_tap_sequencer.sv - per-sample FIR tap sequencer driving sample/coefficient RAM reads and MAC strobes
module fir_tap_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  fir_tap_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, WAIT, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);
  localparam logic [2:0]        DRAIN_LAST = 3'(RD_LATENCY - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] n_last;
  logic [ADDR_W-1:0] k;
  logic [ADDR_W-1:0] sample_rd_addr_q;
  logic [2:0]        drain_cnt;
  logic              overrun_q;

  logic [RD_LATENCY-1:0] en_dly;
  logic [RD_LATENCY-1:0] clr_dly;
  logic [RD_LATENCY-1:0] last_dly;

  logic              accept;
  logic              run_ind;
  logic              first_ind;
  logic              last_ind;
  logic [ADDR_W-1:0] base_cur;
  logic [ADDR_W-1:0] n_cur;
  logic [ADDR_W-1:0] k_nxt;
  logic [ADDR_W-1:0] diff;
  logic [ADDR_W-1:0] rd_addr_nxt;

  assign accept    = bus.sample_en && (state == IDLE);
  assign run_ind   = (state == RUN);
  assign first_ind = run_ind && (k == '0);
  assign last_ind  = run_ind && (k == n_last);

  // Next-state decode; a sample accepted during a coefficient load parks in WAIT
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.sample_en) state_nxt = bus.coef_wr_busy ? WAIT : RUN;
      WAIT:    if (!bus.coef_wr_busy) state_nxt = RUN;
      RUN:     if (k == n_last) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address of the tap that will be presented next cycle; in IDLE the pass parameters are not latched yet
  always_comb begin
    base_cur    = (state == IDLE) ? wr_ptr : base;
    n_cur       = (state == IDLE) ? bus.taps_per_filter : n_last;
    k_nxt       = (state == RUN) ? (k + ONE) : '0;
    diff        = base_cur - k_nxt;
    rd_addr_nxt = (base_cur >= k_nxt) ? diff : (diff + n_cur + ONE);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Circular write pointer and per-pass snapshot of base and tap count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      base   <= '0;
      n_last <= '0;
    end else if (accept) begin
      wr_ptr <= (wr_ptr >= bus.taps_per_filter) ? '0 : (wr_ptr + ONE);
      base   <= wr_ptr;
      n_last <= bus.taps_per_filter;
    end
  end

  // Tap counter and sample read address, loaded only for RUN cycles so both hold afterwards
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k                <= '0;
      sample_rd_addr_q <= '0;
    end else if (state_nxt == RUN) begin
      k                <= k_nxt;
      sample_rd_addr_q <= rd_addr_nxt;
    end
  end

  // Counts DRAIN cycles so the last MAC step lands before result_valid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              drain_cnt <= '0;
    else if (state == DRAIN)   drain_cnt <= drain_cnt + 3'd1;
    else                       drain_cnt <= '0;
  end

  // Delay lines aligning MAC strobes with read data arriving RD_LATENCY cycles after the address
  generate
    if (RD_LATENCY == 1) begin : g_dly1
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          en_dly   <= '0;
          clr_dly  <= '0;
          last_dly <= '0;
        end else begin
          en_dly   <= run_ind;
          clr_dly  <= first_ind;
          last_dly <= last_ind;
        end
      end
    end else begin : g_dlyn
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          en_dly   <= '0;
          clr_dly  <= '0;
          last_dly <= '0;
        end else begin
          en_dly   <= {en_dly[RD_LATENCY-2:0], run_ind};
          clr_dly  <= {clr_dly[RD_LATENCY-2:0], first_ind};
          last_dly <= {last_dly[RD_LATENCY-2:0], last_ind};
        end
      end
    end
  endgenerate

  // Sticky overrun: a sample arriving outside IDLE is dropped and flagged; setting beats clearing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              overrun_q <= 1'b0;
    else if (bus.sample_en && state != IDLE)   overrun_q <= 1'b1;
    else if (bus.overrun_clr)                  overrun_q <= 1'b0;
  end

  assign bus.sample_we      = accept;
  assign bus.sample_wr_addr = wr_ptr;
  assign bus.sample_rd_addr = sample_rd_addr_q;
  assign bus.coef_rd_addr   = k;
  assign bus.mac_en         = en_dly[RD_LATENCY-1];
  assign bus.mac_clr        = clr_dly[RD_LATENCY-1];
  assign bus.mac_last       = last_dly[RD_LATENCY-1];
  assign bus.result_valid   = (state == DONE);
  assign bus.busy           = (state != IDLE);
  assign bus.overrun        = overrun_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb/tb_fir_tap_sequencer.sv - scoreboard bench for fir_tap_sequencer
module tb_fir_tap_sequencer;

  localparam int AW = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  fir_tap_sequencer_if #(.ADDR_W(AW)) ia ();
  fir_tap_sequencer_if #(.ADDR_W(AW)) ib ();

  fir_tap_sequencer #(.ADDR_W(AW), .RD_LATENCY(1)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ia)
  );

  fir_tap_sequencer #(.ADDR_W(AW), .RD_LATENCY(3)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ib)
  );

  typedef struct {
    int d;
    int cyc;
    int v0;
    int v1;
    int v2;
    int v3;
  } ev_t;

  ev_t we_q[$];
  ev_t mac_q[$];
  ev_t rv_q[$];

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int hist_c [2][64];
  int hist_s [2][64];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
    end
  endtask

  task automatic miss(input string name, input int d);
    n_cmp++;
    n_bad++;
    $display("FAIL %s dut%0d at cycle %0d: got event, required none", name, d, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write, MAC step or result
  task automatic mon(input int d, input int lat, input logic we, input logic [7:0] wa,
                     input logic [7:0] ca, input logic [7:0] sa, input logic en,
                     input logic clr, input logic last, input logic rv);
    ev_t e;
    hist_c[d][cyc % 64] = int'(ca);
    hist_s[d][cyc % 64] = int'(sa);
    if (we === 1'b1) begin
      if (we_q.size() == 0) miss("unexpected_sample_we", d);
      else begin
        e = we_q.pop_front();
        chk("we_dut", d, e.d);
        chk("we_cycle", cyc, e.cyc);
        chk("sample_wr_addr", int'(wa), e.v0);
      end
    end
    if (en === 1'b1) begin
      if (mac_q.size() == 0) miss("unexpected_mac_en", d);
      else begin
        e = mac_q.pop_front();
        chk("mac_dut", d, e.d);
        chk("mac_cycle", cyc, e.cyc);
        chk("mac_clr", int'(clr), e.v0);
        chk("mac_last", int'(last), e.v1);
        chk("coef_rd_addr", hist_c[d][(cyc - lat) % 64], e.v2);
        chk("sample_rd_addr", hist_s[d][(cyc - lat) % 64], e.v3);
      end
    end else if (clr === 1'b1 || last === 1'b1) begin
      miss("mac_strobe_without_en", d);
    end
    if (rv === 1'b1) begin
      if (rv_q.size() == 0) miss("unexpected_result_valid", d);
      else begin
        e = rv_q.pop_front();
        chk("rv_dut", d, e.d);
        chk("result_valid_cycle", cyc, e.cyc);
      end
    end
  endtask

  always @(negedge clk) mon(0, 1, ia.sample_we, ia.sample_wr_addr, ia.coef_rd_addr,
                            ia.sample_rd_addr, ia.mac_en, ia.mac_clr, ia.mac_last, ia.result_valid);
  always @(negedge clk) mon(1, 3, ib.sample_we, ib.sample_wr_addr, ib.coef_rd_addr,
                            ib.sample_rd_addr, ib.mac_en, ib.mac_clr, ib.mac_last, ib.result_valid);

  task automatic fire(input int d, input int addr, output int t0);
    @(posedge clk);
    #1;
    t0 = cyc;
    we_q.push_back('{d, t0, addr, 0, 0, 0});
    if (d == 0) ia.sample_en = 1'b1;
    else        ib.sample_en = 1'b1;
    @(posedge clk);
    #1;
    ia.sample_en = 1'b0;
    ib.sample_en = 1'b0;
  endtask

  // sa holds the hand-computed sample read address of tap k in byte k
  task automatic expect_pass(input int d, input int t_run, input int n, input int lat,
                             input logic [31:0] sa);
    for (int k = 0; k < n; k++)
      mac_q.push_back('{d, t_run + k + lat, int'(k == 0), int'(k == n - 1), k,
                        int'((sa >> (8 * k)) & 32'hff)});
    rv_q.push_back('{d, t_run + n + lat, 0, 0, 0, 0});
  endtask

  task automatic wait_idle(input int d);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (((d == 0) ? ia.busy : ib.busy) === 1'b0) done = 1'b1;
    end
    if (!done) miss("idle_timeout", d);
    @(posedge clk);
  endtask

  task automatic chk_zero_a();
    chk("rst_sample_we", int'(ia.sample_we), 0);
    chk("rst_sample_wr_addr", int'(ia.sample_wr_addr), 0);
    chk("rst_sample_rd_addr", int'(ia.sample_rd_addr), 0);
    chk("rst_coef_rd_addr", int'(ia.coef_rd_addr), 0);
    chk("rst_mac_clr", int'(ia.mac_clr), 0);
    chk("rst_mac_en", int'(ia.mac_en), 0);
    chk("rst_mac_last", int'(ia.mac_last), 0);
    chk("rst_result_valid", int'(ia.result_valid), 0);
    chk("rst_busy", int'(ia.busy), 0);
    chk("rst_overrun", int'(ia.overrun), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  logic [31:0] wrap_sa [5];
  int          wrap_wa [5];
  int          t0;

  initial begin
    wrap_sa = '{32'h01020300, 32'h02030001, 32'h03000102, 32'h00010203, 32'h01020300};
    wrap_wa = '{0, 1, 2, 3, 0};
    ia.sample_en = 1'b0; ia.taps_per_filter = 8'd3; ia.coef_wr_busy = 1'b0; ia.overrun_clr = 1'b0;
    ib.sample_en = 1'b0; ib.taps_per_filter = 8'd0; ib.coef_wr_busy = 1'b0; ib.overrun_clr = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero_a();
    chk("rst_b_busy", int'(ib.busy), 0);
    chk("rst_b_mac_en", int'(ib.mac_en), 0);
    reset_n = 1'b1;

    // basic pass: base 0, N=4, L=1
    fire(0, 0, t0);
    expect_pass(0, t0 + 1, 4, 1, 32'h01020300);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk("busy_basic", int'(ia.busy), (c <= 6) ? 1 : 0);
    end
    wait_idle(0);

    // overrun during a pass: base 1
    fire(0, 1, t0);
    expect_pass(0, t0 + 1, 4, 1, 32'h02030001);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ia.sample_en = 1'b1;
    @(negedge clk);
    chk("overrun_before", int'(ia.overrun), 0);
    @(posedge clk); #1;
    ia.sample_en = 1'b0;
    @(negedge clk);
    chk("overrun_set", int'(ia.overrun), 1);
    wait_idle(0);
    chk("overrun_sticky", int'(ia.overrun), 1);
    @(posedge clk); #1;
    ia.overrun_clr = 1'b1;
    @(posedge clk); #1;
    ia.overrun_clr = 1'b0;
    @(negedge clk);
    chk("overrun_cleared", int'(ia.overrun), 0);

    // coefficient-load hold-off: busy falls at cycle 5, RUN from cycle 6; base 2
    ia.coef_wr_busy = 1'b1;
    fire(0, 2, t0);
    expect_pass(0, t0 + 6, 4, 1, 32'h03000102);
    @(posedge clk); #1;
    ia.sample_en   = 1'b1;
    ia.overrun_clr = 1'b1;
    @(negedge clk);
    chk("busy_wait", int'(ia.busy), 1);
    @(posedge clk); #1;
    ia.sample_en = 1'b0;
    @(negedge clk);
    chk("overrun_set_wins", int'(ia.overrun), 1);
    @(posedge clk); #1;
    ia.overrun_clr = 1'b0;
    @(negedge clk);
    chk("overrun_clr_wait", int'(ia.overrun), 0);
    @(posedge clk); #1;
    ia.coef_wr_busy = 1'b0;
    @(negedge clk);
    chk("busy_wait_c5", int'(ia.busy), 1);
    wait_idle(0);

    // async reset mid-pass at cycle 3: only the cycle-2 MAC step happens
    fire(0, 3, t0);
    mac_q.push_back('{0, t0 + 2, 1, 0, 0, 3});
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk_zero_a();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;

    // buffer wrap after reset: writes 0,1,2,3,0; taps changed mid-pass must not matter
    for (int i = 0; i < 5; i++) begin
      fire(0, wrap_wa[i], t0);
      expect_pass(0, t0 + 1, 4, 1, wrap_sa[i]);
      if (i == 1) ia.taps_per_filter = 8'd1;
      wait_idle(0);
      ia.taps_per_filter = 8'd3;
    end

    // single tap, RD_LATENCY=3
    fire(1, 0, t0);
    expect_pass(1, t0 + 1, 1, 3, 32'h0);
    wait_idle(1);

    repeat (6) @(posedge clk);
    chk("we_q_drained", we_q.size(), 0);
    chk("mac_q_drained", mac_q.size(), 0);
    chk("rv_q_drained", rv_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
